// File: rtl/ifm_win_ctrl_if.sv
// Bus bundle between ifm_win_ctrl (master) and the layer FSM, IFM SRAMs, row buffers and PE array.
// stall_cnt is present only when IFM_WIN_STALL_CNT_EN is defined.
interface ifm_win_ctrl_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              stall;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr0;
  logic [ADDR_W-1:0] mem_addr1;
  logic [ADDR_W-1:0] mem_addr2;
  logic              ifm_read;
  logic              win_valid;
  logic [7:0]        win_row;
  logic [7:0]        win_col;
  logic              busy;
  logic              done;
`ifdef IFM_WIN_STALL_CNT_EN
  logic [15:0]       stall_cnt;

  modport master (
    input  start, stall,
    output mem_en, mem_addr0, mem_addr1, mem_addr2, ifm_read,
    output win_valid, win_row, win_col, busy, done, stall_cnt
  );
  modport slave (
    output start, stall,
    input  mem_en, mem_addr0, mem_addr1, mem_addr2, ifm_read,
    input  win_valid, win_row, win_col, busy, done, stall_cnt
  );
`else
  modport master (
    input  start, stall,
    output mem_en, mem_addr0, mem_addr1, mem_addr2, ifm_read,
    output win_valid, win_row, win_col, busy, done
  );
  modport slave (
    output start, stall,
    input  mem_en, mem_addr0, mem_addr1, mem_addr2, ifm_read,
    input  win_valid, win_row, win_col, busy, done
  );
`endif
endinterface

// File: rtl/ifm_win_ctrl.sv
// 3x3 window sequencer: reads IFM rows r..r+2 column by column, shifts the row buffers, flags full windows.
// Optional IFM_WIN_STALL_CNT_EN adds a saturating stall-cycle counter on the bus.
module ifm_win_ctrl #(
  parameter int unsigned IFM_W  = 8,
  parameter int unsigned IFM_H  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input logic            clk,
  input logic            rst_n,
  ifm_win_ctrl_if.master bus
);
  localparam int unsigned RW = $clog2(IFM_H);
  localparam int unsigned CW = $clog2(IFM_W + 1);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IFM_W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_ROW_END, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [CW-1:0]     rd_col_q, rd_col_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d, addr2_q, addr2_d;
  logic              win_valid_q, win_valid_d;
  logic [7:0]        win_row_q, win_row_d, win_col_q, win_col_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              issue_c, shift_c;
  logic [ADDR_W-1:0] base0_c, base1_c, base2_c;

  // Issue and shift strobes are combinational so a stall gates them in the same cycle.
  always_comb begin
    issue_c = (state_q == S_READ) && !bus.stall && (c_q < CW'(IFM_W));
    shift_c = pend_q && !bus.stall;
    base0_c = ADDR_W'(r_q) * W_A + ADDR_W'(c_q);
    base1_c = base0_c + W_A;
    base2_c = base1_c + W_A;
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    rd_col_d    = rd_col_q;
    pend_d      = pend_q;
    addr0_d     = addr0_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_valid_d = shift_c && (rd_col_q >= CW'(2));

    if (win_valid_d) begin
      win_row_d = 8'(r_q);
      win_col_d = 8'(rd_col_q - CW'(2));
    end

    if (issue_c) begin
      pend_d   = 1'b1;
      rd_col_d = c_q;
      c_d      = c_q + CW'(1);
      addr0_d  = base0_c;
      addr1_d  = base1_c;
      addr2_d  = base2_c;
    end else if (shift_c) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_READ: begin
        if (!bus.stall && (c_q == CW'(IFM_W)) && !pend_q) state_d = S_ROW_END;
      end
      S_ROW_END: begin
        if (!bus.stall) begin
          if (r_q == RW'(IFM_H - 3)) begin
            state_d = S_DONE;
          end else begin
            r_d     = r_q + RW'(1);
            c_d     = '0;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_ROW_END);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      rd_col_q    <= '0;
      pend_q      <= 1'b0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      rd_col_q    <= rd_col_d;
      pend_q      <= pend_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Addresses hold their last issued value while mem_en is low.
  assign bus.mem_en    = issue_c;
  assign bus.mem_addr0 = issue_c ? base0_c : addr0_q;
  assign bus.mem_addr1 = issue_c ? base1_c : addr1_q;
  assign bus.mem_addr2 = issue_c ? base2_c : addr2_q;
  assign bus.ifm_read  = shift_c;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef IFM_WIN_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && bus.start) begin
      stall_cnt_d = '0;
    end else if (busy_q && bus.stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
